fpu_arbiter: RTL and testbench

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_fpu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_arbiter.sv
`timescale 1ns/1ps
// Purpose: two-requester round-robin front end that shares one FP multiply(-add) unit.
// Latency: grant in IDLE, ISSUE 1 cycle, WAIT 1..TIMEOUT+1 cycles, RESP 1 cycle (min 4 cycles per op).
// Backpressure: requesters hold valid until ready; responses are one-cycle pulses with no backpressure.
//
// Ports:
//   clock, reset                 - sole clock, asynchronous active-high reset
//   io_reqN_valid/ready/op/a/b/c - requester N handshake (ready only in IDLE) and operands
//   io_respN_valid/bits/error    - one-cycle result pulse for requester N; error marks a timeout
//   io_fpu_{a,b,c}_valid/bits    - operand strobes (ISSUE only) and held operand data to the FP unit
//   io_fpu_result_valid/bits     - FP unit result, honoured only in WAIT
//   io_busy                      - high whenever an operation is in flight
module fpu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              io_req0_valid,
    output logic              io_req0_ready,
    input  logic              io_req0_op,
    input  logic [DATA_W-1:0] io_req0_a,
    input  logic [DATA_W-1:0] io_req0_b,
    input  logic [DATA_W-1:0] io_req0_c,

    input  logic              io_req1_valid,
    output logic              io_req1_ready,
    input  logic              io_req1_op,
    input  logic [DATA_W-1:0] io_req1_a,
    input  logic [DATA_W-1:0] io_req1_b,
    input  logic [DATA_W-1:0] io_req1_c,

    output logic              io_resp0_valid,
    output logic [DATA_W-1:0] io_resp0_bits,
    output logic              io_resp0_error,

    output logic              io_resp1_valid,
    output logic [DATA_W-1:0] io_resp1_bits,
    output logic              io_resp1_error,

    output logic              io_fpu_a_valid,
    output logic [DATA_W-1:0] io_fpu_a_bits,
    output logic              io_fpu_b_valid,
    output logic [DATA_W-1:0] io_fpu_b_bits,
    output logic              io_fpu_c_valid,
    output logic [DATA_W-1:0] io_fpu_c_bits,

    input  logic              io_fpu_result_valid,
    input  logic [DATA_W-1:0] io_fpu_result_bits,

    output logic              io_busy
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic              rr_ptr_q;     // requester favoured when both are valid
    logic              owner_q;      // requester owning the in-flight operation
    logic              op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] c_q;
    logic [DATA_W-1:0] result_q;
    logic              error_q;
    logic [15:0]       cnt_q;
    logic              fpu_ab_vld_q;
    logic              fpu_c_vld_q;
    logic              resp0_vld_q;
    logic              resp1_vld_q;
    logic              busy_q;

    // Grant decode. Requester 1 wins when it is alone or when both are
    // valid and the pointer favours it; otherwise requester 0 wins.
    logic              gnt1;
    logic              take;
    logic              sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] sel_c;

    always_comb begin
        gnt1   = io_req1_valid & (~io_req0_valid | rr_ptr_q);
        // Gated by reset so no handshake can complete while the block is held in reset.
        take   = (state_q == ST_IDLE) & ~reset & (io_req0_valid | io_req1_valid);
        sel_op = gnt1 ? io_req1_op : io_req0_op;
        sel_a  = gnt1 ? io_req1_a  : io_req0_a;
        sel_b  = gnt1 ? io_req1_b  : io_req0_b;
        sel_c  = gnt1 ? io_req1_c  : io_req0_c;
    end

    assign io_req0_ready = take & ~gnt1;
    assign io_req1_ready = take &  gnt1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            cnt_q        <= '0;
            fpu_ab_vld_q <= 1'b0;
            fpu_c_vld_q  <= 1'b0;
            resp0_vld_q  <= 1'b0;
            resp1_vld_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        owner_q      <= gnt1;
                        // Pointer always lands on the requester that was not served.
                        rr_ptr_q     <= ~gnt1;
                        op_q         <= sel_op;
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        c_q          <= sel_c;
                        fpu_ab_vld_q <= 1'b1;
                        fpu_c_vld_q  <= sel_op;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    fpu_ab_vld_q <= 1'b0;
                    fpu_c_vld_q  <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A result on the same cycle as the timeout wins over the abort.
                    if (io_fpu_result_valid) begin
                        result_q    <= io_fpu_result_bits;
                        error_q     <= 1'b0;
                        resp0_vld_q <= ~owner_q;
                        resp1_vld_q <=  owner_q;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == TIMEOUT_CNT) begin
                        result_q    <= '0;
                        error_q     <= 1'b1;
                        resp0_vld_q <= ~owner_q;
                        resp1_vld_q <=  owner_q;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_RESP: begin
                    resp0_vld_q <= 1'b0;
                    resp1_vld_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand data stays on the bus between issues; only the strobes pulse.
    assign io_fpu_a_valid = fpu_ab_vld_q;
    assign io_fpu_b_valid = fpu_ab_vld_q;
    assign io_fpu_c_valid = fpu_c_vld_q;
    assign io_fpu_a_bits  = a_q;
    assign io_fpu_b_bits  = b_q;
    assign io_fpu_c_bits  = c_q;

    // Response data is zeroed outside its pulse so a non-owner never sees stale results.
    assign io_resp0_valid = resp0_vld_q;
    assign io_resp0_bits  = resp0_vld_q ? result_q : '0;
    assign io_resp0_error = resp0_vld_q & error_q;
    assign io_resp1_valid = resp1_vld_q;
    assign io_resp1_bits  = resp1_vld_q ? result_q : '0;
    assign io_resp1_error = resp1_vld_q & error_q;

    assign io_busy = busy_q;

    // op_q is kept for the operand record; the c strobe is already registered from it.
    logic unused_op;
    assign unused_op = op_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
`timescale 1ns/1ps
module tb_fpu_arbiter;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_req0_valid, io_req0_ready, io_req0_op;
    logic [DW-1:0] io_req0_a, io_req0_b, io_req0_c;
    logic          io_req1_valid, io_req1_ready, io_req1_op;
    logic [DW-1:0] io_req1_a, io_req1_b, io_req1_c;
    logic          io_resp0_valid, io_resp0_error, io_resp1_valid, io_resp1_error;
    logic [DW-1:0] io_resp0_bits, io_resp1_bits;
    logic          io_fpu_a_valid, io_fpu_b_valid, io_fpu_c_valid;
    logic [DW-1:0] io_fpu_a_bits, io_fpu_b_bits, io_fpu_c_bits;
    logic          io_fpu_result_valid;
    logic [DW-1:0] io_fpu_result_bits;
    logic          io_busy;

    fpu_arbiter #(.DATA_W(DW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .io_req0_valid(io_req0_valid), .io_req0_ready(io_req0_ready), .io_req0_op(io_req0_op),
        .io_req0_a(io_req0_a), .io_req0_b(io_req0_b), .io_req0_c(io_req0_c),
        .io_req1_valid(io_req1_valid), .io_req1_ready(io_req1_ready), .io_req1_op(io_req1_op),
        .io_req1_a(io_req1_a), .io_req1_b(io_req1_b), .io_req1_c(io_req1_c),
        .io_resp0_valid(io_resp0_valid), .io_resp0_bits(io_resp0_bits), .io_resp0_error(io_resp0_error),
        .io_resp1_valid(io_resp1_valid), .io_resp1_bits(io_resp1_bits), .io_resp1_error(io_resp1_error),
        .io_fpu_a_valid(io_fpu_a_valid), .io_fpu_a_bits(io_fpu_a_bits),
        .io_fpu_b_valid(io_fpu_b_valid), .io_fpu_b_bits(io_fpu_b_bits),
        .io_fpu_c_valid(io_fpu_c_valid), .io_fpu_c_bits(io_fpu_c_bits),
        .io_fpu_result_valid(io_fpu_result_valid), .io_fpu_result_bits(io_fpu_result_bits),
        .io_busy(io_busy)
    );

    always #5 clock = ~clock;

    typedef struct { int port; logic [DW-1:0] bits; logic err; int lat; } exp_t;
    typedef struct { logic op; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] c; } iss_t;
    typedef struct { int dly; logic [DW-1:0] val; } plan_t;

    exp_t  exp_q[$];
    iss_t  iss_q[$];
    plan_t plan_q[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int issue_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({io_req0_ready, io_req1_ready, io_fpu_a_valid, io_fpu_b_valid,
                                  io_fpu_c_valid, io_resp0_valid, io_resp1_valid, io_resp0_error,
                                  io_resp1_error, io_busy}), 64'd0);
        check({tag, "_rbits"}, {io_resp0_bits, io_resp1_bits}, 64'd0);
    endtask

    // Programs the FP unit reply and records what the requester must see.
    // Timeout: reply arrives TIMEOUT+2 cycles after ISSUE with bits 0; otherwise one cycle after the result.
    task automatic expect_op(input int port, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input int dly, input logic [DW-1:0] val,
                             input bit timeout, input bit want_resp);
        iss_t  i;
        plan_t p;
        exp_t  e;
        i.op = op; i.a = a; i.b = b; i.c = c;
        p.dly = dly; p.val = val;
        e.port = port;
        e.bits = timeout ? '0 : val;
        e.err  = timeout;
        e.lat  = timeout ? TO + 2 : dly + 1;
        iss_q.push_back(i);
        plan_q.push_back(p);
        if (want_resp) exp_q.push_back(e);
    endtask

    // Entered and left at #1 after a rising edge; returns during the ISSUE cycle.
    task automatic send(input int port, input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c);
        int   n   = 0;
        logic rdy = 1'b0;
        if (port == 0) begin
            io_req0_valid = 1'b1; io_req0_op = op; io_req0_a = a; io_req0_b = b; io_req0_c = c;
        end else begin
            io_req1_valid = 1'b1; io_req1_op = op; io_req1_a = a; io_req1_b = b; io_req1_c = c;
        end
        while (!rdy && n < 200) begin
            @(negedge clock);
            rdy = (port == 0) ? io_req0_ready : io_req1_ready;
            n++;
        end
        if (!rdy) check($sformatf("grant_timeout_p%0d", port), 64'(rdy), 64'd1);
        @(posedge clock);
        #1;
        if (port == 0) io_req0_valid = 1'b0;
        else           io_req1_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || io_busy) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    // FP unit model: replies after the programmed number of cycles, or never when dly < 0.
    initial begin
        plan_t p;
        io_fpu_result_valid = 1'b0;
        io_fpu_result_bits  = '0;
        forever begin
            @(negedge clock);
            if (!reset && io_fpu_a_valid && plan_q.size() > 0) begin
                p = plan_q.pop_front();
                if (p.dly > 0) begin
                    repeat (p.dly) @(posedge clock);
                    #1;
                    io_fpu_result_valid = 1'b1;
                    io_fpu_result_bits  = p.val;
                    @(posedge clock);
                    #1;
                    io_fpu_result_valid = 1'b0;
                    io_fpu_result_bits  = '0;
                end
            end
        end
    end

    // Scoreboard: compares every ISSUE and every response pulse against the queues.
    initial begin
        iss_t e_i;
        exp_t e_r;
        logic [DW-1:0] rbits;
        logic          rerr;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("ready_exclusive", 64'(io_req0_ready & io_req1_ready), 64'd0);
                if (io_fpu_a_valid) begin
                    if (iss_q.size() == 0) begin
                        check("issue_unexpected", 64'(io_fpu_a_valid), 64'd0);
                    end else begin
                        e_i = iss_q.pop_front();
                        issue_cyc = cyc;
                        check("iss_b_valid", 64'(io_fpu_b_valid), 64'd1);
                        check("iss_c_valid", 64'(io_fpu_c_valid), 64'(e_i.op));
                        check("iss_a_bits", 64'(io_fpu_a_bits), 64'(e_i.a));
                        check("iss_b_bits", 64'(io_fpu_b_bits), 64'(e_i.b));
                        if (e_i.op) check("iss_c_bits", 64'(io_fpu_c_bits), 64'(e_i.c));
                    end
                end else begin
                    check("strobes_idle", 64'({io_fpu_b_valid, io_fpu_c_valid}), 64'd0);
                end
                if (io_resp0_valid || io_resp1_valid) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 64'({io_resp0_valid, io_resp1_valid}), 64'd0);
                    end else begin
                        e_r   = exp_q.pop_front();
                        rbits = io_resp1_valid ? io_resp1_bits  : io_resp0_bits;
                        rerr  = io_resp1_valid ? io_resp1_error : io_resp0_error;
                        check("resp_port", 64'({io_resp0_valid, io_resp1_valid}),
                              (e_r.port == 0) ? 64'd2 : 64'd1);
                        check("resp_bits", 64'(rbits), 64'(e_r.bits));
                        check("resp_error", 64'(rerr), 64'(e_r.err));
                        check("resp_latency", 64'(cyc - issue_cyc), 64'(e_r.lat));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        io_req0_valid = 1'b1; io_req0_op = 1'b0; io_req0_a = '0; io_req0_b = '0; io_req0_c = '0;
        io_req1_valid = 1'b0; io_req1_op = 1'b0; io_req1_a = '0; io_req1_b = '0; io_req1_c = '0;

        // Reset state, with a request pending that must not be accepted.
        repeat (2) @(posedge clock);
        #1;
        check_quiet("reset_state");
        check("reset_operands", 64'(io_fpu_a_bits | io_fpu_b_bits | io_fpu_c_bits), 64'd0);
        io_req0_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // FMA on requester 0, FP unit answers 3 cycles after ISSUE.
        expect_op(0, 1'b1, 32'h3f800000, 32'h40000000, 32'h3f800000, 3, 32'h40400000, 1'b0, 1'b1);
        send(0, 1'b1, 32'h3f800000, 32'h40000000, 32'h3f800000);
        check("busy_in_issue", 64'(io_busy), 64'd1);
        wait_drain("drain_fma");
        check("busy_after", 64'(io_busy), 64'd0);

        // Multiply on requester 1: no c strobe, response on port 1 only.
        expect_op(1, 1'b0, 32'h11111111, 32'h22222222, 32'hdeadbeef, 1, 32'h12345678, 1'b0, 1'b1);
        send(1, 1'b0, 32'h11111111, 32'h22222222, 32'hdeadbeef);
        wait_drain("drain_mul1");

        // Fresh reset, then both requesters contend with two ops each: 0,1,0,1.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        expect_op(0, 1'b0, 32'h0000000a, 32'h000000a0, 32'h0, 1, 32'haaaa0001, 1'b0, 1'b1);
        expect_op(1, 1'b0, 32'h0000000b, 32'h000000b0, 32'h0, 2, 32'hbbbb0001, 1'b0, 1'b1);
        expect_op(0, 1'b0, 32'h0000000c, 32'h000000c0, 32'h0, 1, 32'haaaa0002, 1'b0, 1'b1);
        expect_op(1, 1'b0, 32'h0000000d, 32'h000000d0, 32'h0, 2, 32'hbbbb0002, 1'b0, 1'b1);
        fork
            begin
                send(0, 1'b0, 32'h0000000a, 32'h000000a0, 32'h0);
                send(0, 1'b0, 32'h0000000c, 32'h000000c0, 32'h0);
            end
            begin
                send(1, 1'b0, 32'h0000000b, 32'h000000b0, 32'h0);
                send(1, 1'b0, 32'h0000000d, 32'h000000d0, 32'h0);
            end
        join
        wait_drain("drain_rr");

        // FP unit silent: error response 10 cycles after ISSUE, then a normal op.
        expect_op(0, 1'b0, 32'h00000005, 32'h00000006, 32'h0, -1, 32'h0, 1'b1, 1'b1);
        send(0, 1'b0, 32'h00000005, 32'h00000006, 32'h0);
        wait_drain("drain_timeout");
        expect_op(1, 1'b1, 32'h00000007, 32'h00000008, 32'h00000009, 2, 32'hcafef00d, 1'b0, 1'b1);
        send(1, 1'b1, 32'h00000007, 32'h00000008, 32'h00000009);
        wait_drain("drain_after_timeout");

        // Result exactly when the counter hits TIMEOUT counts as success.
        expect_op(0, 1'b1, 32'h01010101, 32'h02020202, 32'h03030303, TO + 1, 32'h0badcafe, 1'b0, 1'b1);
        send(0, 1'b1, 32'h01010101, 32'h02020202, 32'h03030303);
        wait_drain("drain_edge_ok");

        // One cycle later is too late: timeout error, late result ignored in RESP.
        expect_op(1, 1'b0, 32'h04040404, 32'h05050505, 32'h0, TO + 2, 32'h55555555, 1'b1, 1'b1);
        send(1, 1'b0, 32'h04040404, 32'h05050505, 32'h0);
        wait_drain("drain_edge_late");

        // Reset during WAIT: no response, late FP result ignored, everything quiet.
        expect_op(1, 1'b1, 32'h0f0f0f0f, 32'h0e0e0e0e, 32'h0d0d0d0d, 8, 32'h77777777, 1'b0, 1'b0);
        send(1, 1'b1, 32'h0f0f0f0f, 32'h0e0e0e0e, 32'h0d0d0d0d);
        repeat (3) @(posedge clock);
        #1;
        check("busy_in_wait", 64'(io_busy), 64'd1);
        reset = 1'b1;
        #1;
        check_quiet("mid_reset");
        check("mid_reset_operands", 64'(io_fpu_a_bits | io_fpu_b_bits | io_fpu_c_bits), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check_quiet("post_reset");
        check("post_reset_exp", 64'(exp_q.size()), 64'd0);

        // Service resumes normally after the abandoned operation.
        expect_op(0, 1'b0, 32'h00000003, 32'h00000004, 32'h0, 1, 32'h13579bdf, 1'b0, 1'b1);
        send(0, 1'b0, 32'h00000003, 32'h00000004, 32'h0);
        wait_drain("drain_final");
        check("issue_queue_empty", 64'(iss_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
